// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Fills the byte-addressed, little-endian instruction memory from a byte
// stream. Bytes are packed four at a time into 32-bit words, with the first
// byte going into the least significant lane. Each completed word is issued as
// one word write. A trailing two's-complement checksum byte closes the load.
// The core is held in reset (core_hold) until a load finishes with a good
// checksum.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle load request (honoured only when idle)
//   num_words    number of words to load, sampled with start
//   s_valid      stream byte valid
//   s_data       stream byte
//   s_ready      loader accepts a byte this cycle (RECV / CKSUM only)
//   w_en_imem    word write strobe
//   w_addr_imem  4-aligned byte address of the word being written
//   w_data_imem  word being written (byte k lands at w_addr_imem+k)
//   busy         high whenever the loader is not idle
//   done         one-cycle pulse at the end of a load
//   cksum_err    sticky checksum mismatch flag, cleared by the next load
//   len_err      one-cycle pulse when start requests more words than fit
//   core_hold    keeps the core in reset
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 7,
  parameter int CNT_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              w_en_imem,
  output logic [ADDR_W-1:0] w_addr_imem,
  output logic [31:0]       w_data_imem,
  output logic              busy,
  output logic              done,
  output logic              cksum_err,
  output logic              len_err,
  output logic              core_hold
);

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CKSUM,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [31:0]       word_q, word_asm;

  logic              w_en_q;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [31:0]       w_data_q, w_data_d;
  logic              busy_q, done_q;
  logic              cksum_err_q, cksum_err_d;
  logic              len_err_q, len_err_d;
  logic              core_hold_q, core_hold_d;

  logic              xfer;
  logic [7:0]        sum_plus;
  logic [CNT_W-1:0]  word_idx_inc;

  // s_ready is the only combinational output: a pure decode of the state.
  assign s_ready      = (state_q == S_RECV) || (state_q == S_CKSUM);
  assign xfer         = s_valid && s_ready;
  assign sum_plus     = sum_q + s_data;
  assign word_idx_inc = word_idx_q + CNT_W'(1);

  // Lane steering: an accepted data byte overwrites lane byte_idx, all other
  // lanes keep their contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_asm[8*gi +: 8] =
      (state_q == S_RECV && xfer && byte_idx_q == 2'(gi)) ? s_data : word_q[8*gi +: 8];
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    sum_d       = sum_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    cksum_err_d = cksum_err_q;
    len_err_d   = 1'b0;
    core_hold_d = core_hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = S_DONE;
          end else if (num_words > MAX_WORDS) begin
            len_err_d = 1'b1;
          end else begin
            count_d     = num_words;
            sum_d       = '0;
            byte_idx_d  = '0;
            word_idx_d  = '0;
            cksum_err_d = 1'b0;
            core_hold_d = 1'b1;
            state_d     = S_RECV;
          end
        end
      end

      S_RECV: begin
        if (xfer) begin
          sum_d      = sum_plus;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Capture the complete word (including this 4th byte) so the
            // write strobe in WRITE carries it.
            w_addr_d = ADDR_W'({word_idx_q, 2'b00});
            w_data_d = word_asm;
            state_d  = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        word_idx_d = word_idx_inc;
        byte_idx_d = '0;
        state_d    = (word_idx_inc == count_q) ? S_CKSUM : S_RECV;
      end

      S_CKSUM: begin
        if (xfer) begin
          if (sum_plus != 8'h00) begin
            cksum_err_d = 1'b1;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Release decision is taken on entry to DONE so core_hold is already
    // valid while done is pulsing.
    if (state_d == S_DONE && state_q != S_DONE) begin
      core_hold_d = cksum_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      sum_q       <= '0;
      word_q      <= '0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cksum_err_q <= 1'b0;
      len_err_q   <= 1'b0;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      sum_q       <= sum_d;
      word_q      <= word_asm;
      w_en_q      <= (state_d == S_WRITE);
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      cksum_err_q <= cksum_err_d;
      len_err_q   <= len_err_d;
      core_hold_q <= core_hold_d;
    end
  end

  assign w_en_imem   = w_en_q;
  assign w_addr_imem = w_addr_q;
  assign w_data_imem = w_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cksum_err   = cksum_err_q;
  assign len_err     = len_err_q;
  assign core_hold   = core_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader: directed self-checking bench for imem_loader.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  num_words = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        w_en_imem;
  logic [6:0]  w_addr_imem;
  logic [31:0] w_data_imem;
  logic        busy;
  logic        done;
  logic        cksum_err;
  logic        len_err;
  logic        core_hold;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  logic [6:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tb_bytes[0:127];

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_words   (num_words),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .w_en_imem   (w_en_imem),
    .w_addr_imem (w_addr_imem),
    .w_data_imem (w_data_imem),
    .busy        (busy),
    .done        (done),
    .cksum_err   (cksum_err),
    .len_err     (len_err),
    .core_hold   (core_hold)
  );

  always #5 clk = ~clk;

  // Write monitor: logs every word write and checks the stream is stalled
  // during the write cycle.
  always @(negedge clk) begin
    if (rst_n && w_en_imem) begin
      wr_addr_q.push_back(w_addr_imem);
      wr_data_q.push_back(w_data_imem);
      $display("write addr=%0d data=%08h", w_addr_imem, w_data_imem);
      checks++;
      if (s_ready !== 1'b0) begin
        $display("FAIL write_stall s_ready=%b required=0", s_ready);
        failures++;
      end
    end
    if (rst_n && s_valid && s_ready) acc_cnt++;
  end

  // Drive one byte and hold it until accepted. Caller is at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%02h not accepted within 50 cycles", b);
      s_valid = 1'b0;
    end
  endtask

  task automatic do_start(input logic [5:0] n);
    start = 1'b1;
    num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_load(input logic [5:0] n, input logic [7:0] ck, input bit gaps, output bit seen);
    do_start(n);
    for (int i = 0; i < 4 * int'(n); i++)
      send_byte(tb_bytes[i], gaps ? int'($urandom_range(0, 3)) : 0);
    send_byte(ck, gaps ? int'($urandom_range(0, 3)) : 0);
    wait_done(seen);
  endtask

  task automatic test_reset;
    checks++; if (s_ready !== 1'b0)       begin $display("FAIL rst_s_ready got=%b exp=0", s_ready); failures++; end
    checks++; if (w_en_imem !== 1'b0)     begin $display("FAIL rst_w_en got=%b exp=0", w_en_imem); failures++; end
    checks++; if (w_addr_imem !== 7'd0)   begin $display("FAIL rst_w_addr got=%0d exp=0", w_addr_imem); failures++; end
    checks++; if (w_data_imem !== 32'd0)  begin $display("FAIL rst_w_data got=%08h exp=0", w_data_imem); failures++; end
    checks++; if (busy !== 1'b0)          begin $display("FAIL rst_busy got=%b exp=0", busy); failures++; end
    checks++; if (done !== 1'b0)          begin $display("FAIL rst_done got=%b exp=0", done); failures++; end
    checks++; if (cksum_err !== 1'b0)     begin $display("FAIL rst_cksum_err got=%b exp=0", cksum_err); failures++; end
    checks++; if (len_err !== 1'b0)       begin $display("FAIL rst_len_err got=%b exp=0", len_err); failures++; end
    checks++; if (core_hold !== 1'b1)     begin $display("FAIL rst_core_hold got=%b exp=1", core_hold); failures++; end
  endtask

  task automatic test_single_word;
    bit seen;
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(6'd1);
    checks++; if (busy !== 1'b1) begin $display("FAIL single_busy got=%b exp=1", busy); failures++; end
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    checks++; if (w_en_imem !== 1'b1)          begin $display("FAIL single_w_en got=%b exp=1", w_en_imem); failures++; end
    checks++; if (w_addr_imem !== 7'd0)        begin $display("FAIL single_addr got=%0d exp=0", w_addr_imem); failures++; end
    checks++; if (w_data_imem !== 32'h00000013) begin $display("FAIL single_data got=%08h exp=00000013", w_data_imem); failures++; end
    send_byte(8'hED, 0);
    wait_done(seen);
    checks++; if (seen !== 1'b1)       begin $display("FAIL single_done got=%b exp=1", seen); failures++; end
    checks++; if (cksum_err !== 1'b0)  begin $display("FAIL single_cksum_err got=%b exp=0", cksum_err); failures++; end
    checks++; if (core_hold !== 1'b0)  begin $display("FAIL single_core_hold got=%b exp=0", core_hold); failures++; end
    checks++; if (wr_addr_q.size() != 1) begin $display("FAIL single_nwrites got=%0d exp=1", wr_addr_q.size()); failures++; end
  endtask

  task automatic test_full_memory;
    bit seen;
    int n;
    for (int i = 0; i < 128; i++) tb_bytes[i] = 8'(i);
    wr_addr_q.delete(); wr_data_q.delete();
    acc_cnt = 0;
    // Sum of 0..127 is 8128 = 0xC0 mod 256, so the checksum byte is 0x40.
    run_load(6'd32, 8'h40, 1'b0, seen);
    checks++; if (seen !== 1'b1) begin $display("FAIL full_done got=%b exp=1", seen); failures++; end
    checks++; if (wr_addr_q.size() != 32) begin $display("FAIL full_nwrites got=%0d exp=32", wr_addr_q.size()); failures++; end
    checks++; if (acc_cnt != 129) begin $display("FAIL full_bytes_accepted got=%0d exp=129", acc_cnt); failures++; end
    n = (wr_addr_q.size() < 32) ? wr_addr_q.size() : 32;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (wr_addr_q[i] !== 7'(4 * i) ||
          wr_data_q[i] !== {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}) begin
        $display("FAIL full_word%0d got addr=%0d data=%08h exp addr=%0d", i, wr_addr_q[i], wr_data_q[i], 4 * i);
        failures++;
      end
    end
    if (n == 32) begin
      checks++; if (wr_data_q[1] !== 32'h07060504)  begin $display("FAIL full_word1 got=%08h exp=07060504", wr_data_q[1]); failures++; end
      checks++; if (wr_addr_q[31] !== 7'd124)       begin $display("FAIL full_last_addr got=%0d exp=124", wr_addr_q[31]); failures++; end
      checks++; if (wr_data_q[31] !== 32'h7F7E7D7C) begin $display("FAIL full_last_data got=%08h exp=7F7E7D7C", wr_data_q[31]); failures++; end
    end
    checks++; if (cksum_err !== 1'b0) begin $display("FAIL full_cksum_err got=%b exp=0", cksum_err); failures++; end
    checks++; if (core_hold !== 1'b0) begin $display("FAIL full_core_hold got=%b exp=0", core_hold); failures++; end
  endtask

  task automatic test_bad_cksum;
    bit seen;
    logic [7:0] vec [0:7];
    vec = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) tb_bytes[i] = vec[i];
    wr_addr_q.delete(); wr_data_q.delete();
    // Data sums to 0x64; good checksum would be 0x9C, send 0x9D.
    run_load(6'd2, 8'h9D, 1'b0, seen);
    checks++; if (seen !== 1'b1) begin $display("FAIL bad_done got=%b exp=1", seen); failures++; end
    checks++; if (wr_addr_q.size() != 2) begin $display("FAIL bad_nwrites got=%0d exp=2", wr_addr_q.size()); failures++; end
    if (wr_addr_q.size() == 2) begin
      checks++; if (wr_addr_q[0] !== 7'd0 || wr_data_q[0] !== 32'h44332211) begin $display("FAIL bad_word0 got addr=%0d data=%08h exp addr=0 data=44332211", wr_addr_q[0], wr_data_q[0]); failures++; end
      checks++; if (wr_addr_q[1] !== 7'd4 || wr_data_q[1] !== 32'h88776655) begin $display("FAIL bad_word1 got addr=%0d data=%08h exp addr=4 data=88776655", wr_addr_q[1], wr_data_q[1]); failures++; end
    end
    checks++; if (cksum_err !== 1'b1) begin $display("FAIL bad_cksum_err got=%b exp=1", cksum_err); failures++; end
    checks++; if (core_hold !== 1'b1) begin $display("FAIL bad_core_hold got=%b exp=1", core_hold); failures++; end
    repeat (5) @(posedge clk); #1;
    checks++; if (cksum_err !== 1'b1) begin $display("FAIL bad_cksum_sticky got=%b exp=1", cksum_err); failures++; end
    checks++; if (core_hold !== 1'b1) begin $display("FAIL bad_core_hold_sticky got=%b exp=1", core_hold); failures++; end
  endtask

  task automatic test_backpressure;
    bit seen;
    for (int i = 0; i < 12; i++) tb_bytes[i] = 8'hA0 + 8'(i);
    // Data sums to 0xC2, checksum byte 0x3E.
    for (int pass = 0; pass < 2; pass++) begin
      wr_addr_q.delete(); wr_data_q.delete();
      run_load(6'd3, 8'h3E, pass == 1, seen);
      checks++; if (seen !== 1'b1) begin $display("FAIL bp%0d_done got=%b exp=1", pass, seen); failures++; end
      checks++; if (wr_addr_q.size() != 3) begin $display("FAIL bp%0d_nwrites got=%0d exp=3", pass, wr_addr_q.size()); failures++; end
      if (wr_addr_q.size() == 3) begin
        checks++; if (wr_addr_q[0] !== 7'd0 || wr_data_q[0] !== 32'hA3A2A1A0) begin $display("FAIL bp%0d_word0 got addr=%0d data=%08h exp addr=0 data=A3A2A1A0", pass, wr_addr_q[0], wr_data_q[0]); failures++; end
        checks++; if (wr_addr_q[1] !== 7'd4 || wr_data_q[1] !== 32'hA7A6A5A4) begin $display("FAIL bp%0d_word1 got addr=%0d data=%08h exp addr=4 data=A7A6A5A4", pass, wr_addr_q[1], wr_data_q[1]); failures++; end
        checks++; if (wr_addr_q[2] !== 7'd8 || wr_data_q[2] !== 32'hABAAA9A8) begin $display("FAIL bp%0d_word2 got addr=%0d data=%08h exp addr=8 data=ABAAA9A8", pass, wr_addr_q[2], wr_data_q[2]); failures++; end
      end
      checks++; if (cksum_err !== 1'b0) begin $display("FAIL bp%0d_cksum_err got=%b exp=0", pass, cksum_err); failures++; end
      checks++; if (core_hold !== 1'b0) begin $display("FAIL bp%0d_core_hold got=%b exp=0", pass, core_hold); failures++; end
    end
  endtask

  task automatic test_length_edges;
    bit seen;
    wr_addr_q.delete(); wr_data_q.delete();
    // Zero-length load.
    do_start(6'd0);
    @(negedge clk);
    checks++; if (done !== 1'b1)      begin $display("FAIL zero_done got=%b exp=1", done); failures++; end
    checks++; if (w_en_imem !== 1'b0) begin $display("FAIL zero_w_en got=%b exp=0", w_en_imem); failures++; end
    @(negedge clk);
    checks++; if (done !== 1'b0)      begin $display("FAIL zero_done_pulse got=%b exp=0", done); failures++; end
    checks++; if (busy !== 1'b0)      begin $display("FAIL zero_busy got=%b exp=0", busy); failures++; end
    checks++; if (wr_addr_q.size() != 0) begin $display("FAIL zero_nwrites got=%0d exp=0", wr_addr_q.size()); failures++; end
    @(posedge clk); #1;
    // Oversized request.
    do_start(6'd33);
    @(negedge clk);
    checks++; if (len_err !== 1'b1)   begin $display("FAIL len33_len_err got=%b exp=1", len_err); failures++; end
    checks++; if (busy !== 1'b0)      begin $display("FAIL len33_busy got=%b exp=0", busy); failures++; end
    checks++; if (s_ready !== 1'b0)   begin $display("FAIL len33_s_ready got=%b exp=0", s_ready); failures++; end
    @(negedge clk);
    checks++; if (len_err !== 1'b0)   begin $display("FAIL len33_pulse got=%b exp=0", len_err); failures++; end
    checks++; if (core_hold !== 1'b0) begin $display("FAIL len33_core_hold got=%b exp=0", core_hold); failures++; end
    @(posedge clk); #1;
    // start during RECV must not disturb the running load.
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(6'd1);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    do_start(6'd5);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'hF6, 0);
    wait_done(seen);
    checks++; if (seen !== 1'b1) begin $display("FAIL busy_start_done got=%b exp=1", seen); failures++; end
    checks++; if (wr_addr_q.size() != 1) begin $display("FAIL busy_start_nwrites got=%0d exp=1", wr_addr_q.size()); failures++; end
    if (wr_addr_q.size() == 1) begin
      checks++; if (wr_data_q[0] !== 32'h04030201) begin $display("FAIL busy_start_data got=%08h exp=04030201", wr_data_q[0]); failures++; end
    end
    checks++; if (cksum_err !== 1'b0) begin $display("FAIL busy_start_cksum_err got=%b exp=0", cksum_err); failures++; end
    checks++; if (busy !== 1'b0)      begin $display("FAIL busy_start_idle got=%b exp=0", busy); failures++; end
  endtask

  task automatic test_reset_mid_load;
    bit seen;
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(6'd2);
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 0);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (core_hold !== 1'b1)    begin $display("FAIL midrst_core_hold got=%b exp=1", core_hold); failures++; end
    checks++; if (busy !== 1'b0)         begin $display("FAIL midrst_busy got=%b exp=0", busy); failures++; end
    checks++; if (s_ready !== 1'b0)      begin $display("FAIL midrst_s_ready got=%b exp=0", s_ready); failures++; end
    checks++; if (w_en_imem !== 1'b0)    begin $display("FAIL midrst_w_en got=%b exp=0", w_en_imem); failures++; end
    checks++; if (w_addr_imem !== 7'd0)  begin $display("FAIL midrst_w_addr got=%0d exp=0", w_addr_imem); failures++; end
    checks++; if (w_data_imem !== 32'd0) begin $display("FAIL midrst_w_data got=%08h exp=0", w_data_imem); failures++; end
    checks++; if (wr_addr_q.size() != 1) begin $display("FAIL midrst_nwrites got=%0d exp=1", wr_addr_q.size()); failures++; end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    wr_addr_q.delete(); wr_data_q.delete();
    tb_bytes[0] = 8'hDE; tb_bytes[1] = 8'hAD; tb_bytes[2] = 8'hBE; tb_bytes[3] = 8'hEF;
    // Data sums to 0x38, checksum byte 0xC8.
    run_load(6'd1, 8'hC8, 1'b0, seen);
    checks++; if (seen !== 1'b1) begin $display("FAIL postrst_done got=%b exp=1", seen); failures++; end
    checks++; if (wr_addr_q.size() != 1) begin $display("FAIL postrst_nwrites got=%0d exp=1", wr_addr_q.size()); failures++; end
    if (wr_addr_q.size() == 1) begin
      checks++; if (wr_addr_q[0] !== 7'd0 || wr_data_q[0] !== 32'hEFBEADDE) begin $display("FAIL postrst_word got addr=%0d data=%08h exp addr=0 data=EFBEADDE", wr_addr_q[0], wr_data_q[0]); failures++; end
    end
    checks++; if (core_hold !== 1'b0) begin $display("FAIL postrst_core_hold got=%b exp=0", core_hold); failures++; end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_single_word;
    test_full_memory;
    test_bad_cksum;
    test_backpressure;
    test_length_edges;
    test_reset_mid_load;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
